// File: rtl/brus16_pkg.sv
// Shared brus16 constants: RAM geometry, loader sync marker and loader FSM states.
// The CHK_* states exist only when LOADER_CHECKSUM_EN is defined.
package brus16_pkg;

    localparam int         RAM_ADDR_WIDTH = 13;
    localparam int         RAM_DATA_WIDTH = 16;
    localparam logic [7:0] DEF_SYNC_BYTE  = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA_LO,
        DATA_HI,
`ifdef LOADER_CHECKSUM_EN
        CHK_LO,
        CHK_HI,
`endif
        FINISH
    } loader_state_t;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Byte-stream input and RAM write / CPU control outputs of the program loader.
interface uart_prog_loader_if
    import brus16_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_DATA_WIDTH
);
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic                  cpu_reset;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        input  rx_valid, rx_data,
        output mem_we, mem_addr, mem_din, cpu_reset, busy, done, error
    );

    modport slave (
        output rx_valid, rx_data,
        input  mem_we, mem_addr, mem_din, cpu_reset, busy, done, error
    );
endinterface

// File: rtl/uart_prog_loader_timeout.sv
// Inter-byte watchdog: reloads on clear, counts down while enabled, flags expiry at zero.
module loader_timeout #(
    parameter int unsigned CYCLES = 27000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expire
);
    localparam int W = (CYCLES > 2) ? $clog2(CYCLES) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= W'(CYCLES - 1);
        else if (en && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign expire = en && (cnt == '0);
endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: frames a UART byte stream and writes little-endian words into program RAM.
// Define LOADER_CHECKSUM_EN to append and verify a 16-bit modular checksum per frame.
module uart_prog_loader
    import brus16_pkg::*;
#(
    parameter int          ADDR_WIDTH     = RAM_ADDR_WIDTH,
    parameter int          DATA_WIDTH     = RAM_DATA_WIDTH,
    parameter logic [7:0]  SYNC_BYTE      = DEF_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 27000000
) (
    input  logic                clk,
    input  logic                reset,
    uart_prog_loader_if.master  bus
);
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

    loader_state_t         state, state_n;
    logic                  we_n, cpu_n, busy_n, done_n, err_n;
    logic [ADDR_WIDTH-1:0] addr_n, idx, idx_n;
    logic [DATA_WIDTH-1:0] din_n;
    logic [15:0]           left, left_n, word;
    logic [7:0]            lo, lo_n;
    logic                  expire;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0]           sum, sum_n;
`endif

    assign word = {bus.rx_data, lo};

    loader_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (bus.rx_valid),
        .en     (bus.busy),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_din   <= '0;
            bus.cpu_reset <= 1'b1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.error     <= 1'b0;
            idx           <= '0;
            left          <= '0;
            lo            <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum           <= '0;
`endif
        end else begin
            state         <= state_n;
            bus.mem_we    <= we_n;
            bus.mem_addr  <= addr_n;
            bus.mem_din   <= din_n;
            bus.cpu_reset <= cpu_n;
            bus.busy      <= busy_n;
            bus.done      <= done_n;
            bus.error     <= err_n;
            idx           <= idx_n;
            left          <= left_n;
            lo            <= lo_n;
`ifdef LOADER_CHECKSUM_EN
            sum           <= sum_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        we_n    = 1'b0;
        addr_n  = bus.mem_addr;
        din_n   = bus.mem_din;
        cpu_n   = bus.cpu_reset;
        busy_n  = bus.busy;
        done_n  = bus.done;
        err_n   = bus.error;
        idx_n   = idx;
        left_n  = left;
        lo_n    = lo;
`ifdef LOADER_CHECKSUM_EN
        sum_n   = sum;
`endif
        unique case (state)
            FINISH: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                cpu_n   = 1'b0;
                state_n = IDLE;
            end
            default: begin
                // A watchdog expiry swallows any byte arriving in the same cycle
                if (expire) begin
                    err_n   = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (bus.rx_valid) begin
                    unique case (state)
                        IDLE: if (bus.rx_data == SYNC_BYTE) begin
                            busy_n  = 1'b1;
                            cpu_n   = 1'b1;
                            done_n  = 1'b0;
                            err_n   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                            sum_n   = '0;
`endif
                            state_n = LEN_LO;
                        end
                        LEN_LO: begin
                            lo_n    = bus.rx_data;
                            state_n = LEN_HI;
                        end
                        LEN_HI: begin
                            left_n = word;
                            idx_n  = '0;
                            if (word == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                                state_n = CHK_LO;
`else
                                state_n = FINISH;
`endif
                            end else if ({16'd0, word} > MAX_WORDS) begin
                                err_n   = 1'b1;
                                busy_n  = 1'b0;
                                state_n = IDLE;
                            end else begin
                                state_n = DATA_LO;
                            end
                        end
                        DATA_LO: begin
                            lo_n    = bus.rx_data;
                            state_n = DATA_HI;
                        end
                        DATA_HI: begin
                            we_n   = 1'b1;
                            din_n  = DATA_WIDTH'(word);
                            addr_n = idx;
                            idx_n  = idx + ADDR_WIDTH'(1);
                            left_n = left - 16'd1;
`ifdef LOADER_CHECKSUM_EN
                            sum_n  = sum + word;
                            state_n = (left == 16'd1) ? CHK_LO : DATA_LO;
`else
                            state_n = (left == 16'd1) ? FINISH : DATA_LO;
`endif
                        end
`ifdef LOADER_CHECKSUM_EN
                        CHK_LO: begin
                            lo_n    = bus.rx_data;
                            state_n = CHK_HI;
                        end
                        CHK_HI: begin
                            if (word == sum) begin
                                state_n = FINISH;
                            end else begin
                                err_n   = 1'b1;
                                busy_n  = 1'b0;
                                state_n = IDLE;
                            end
                        end
`endif
                        default: state_n = IDLE;
                    endcase
                end
            end
        endcase
    end
endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: frame table plus timeout, length-boundary and async-reset sequences.
module tb_uart_prog_loader;
    import brus16_pkg::*;

    typedef struct {
        int          nb;
        logic [79:0] b;     // bytes right-aligned, first byte sent is the most significant
        int          nw;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        dn;
        logic        er;
        logic        cp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    uart_prog_loader_if bus ();

    uart_prog_loader #(.TIMEOUT_CYCLES(100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int last_rx = 0;
    int wr_total = 0;
    logic [12:0] wr_addr [16];
    logic [15:0] wr_din  [16];
    int          wr_lat  [16];
    int pass = 0;
    int total = 0;

`ifdef LOADER_CHECKSUM_EN
    localparam int NV = 7;
`else
    localparam int NV = 5;
`endif
    vec_t vecs [NV];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mem_we) begin
            wr_addr[wr_total % 16] <= bus.mem_addr;
            wr_din[wr_total % 16]  <= bus.mem_din;
            wr_lat[wr_total % 16]  <= cyc - last_rx;
            wr_total               <= wr_total + 1;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic vec_t mkv(int nb, logic [79:0] b, int nw, logic [15:0] d0, logic [15:0] d1,
                                 logic dn, logic er, logic cp);
        vec_t v;
        v.nb = nb; v.b = b; v.nw = nw; v.d0 = d0; v.d1 = d1; v.dn = dn; v.er = er; v.cp = cp;
        return v;
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        last_rx      = cyc;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic apply(input int k);
        vec_t v;
        int base;
        logic [15:0] ed;
        v = vecs[k];
        base = wr_total;
        for (int j = 0; j < v.nb; j++) send(v.b[8*(v.nb-1-j) +: 8]);
        repeat (4) @(negedge clk);
        check($sformatf("v%0d writes", k), 32'(wr_total - base), 32'(v.nw));
        for (int i = 0; i < v.nw && i < 2; i++) begin
            ed = (i == 0) ? v.d0 : v.d1;
            check($sformatf("v%0d w%0d addr", k, i), 32'(wr_addr[(base+i)%16]), 32'(i));
            check($sformatf("v%0d w%0d din", k, i), 32'(wr_din[(base+i)%16]), 32'(ed));
            check($sformatf("v%0d w%0d latency", k, i), 32'(wr_lat[(base+i)%16]), 32'd1);
        end
        check($sformatf("v%0d done", k), 32'(bus.done), 32'(v.dn));
        check($sformatf("v%0d error", k), 32'(bus.error), 32'(v.er));
        check($sformatf("v%0d cpu_reset", k), 32'(bus.cpu_reset), 32'(v.cp));
        check($sformatf("v%0d busy", k), 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int base;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        reset        = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        vecs[0] = mkv(9, 80'hA5_02_00_34_12_78_56_AC_68, 2, 16'h1234, 16'h5678, 1, 0, 0);
        vecs[1] = mkv(9, 80'h00_FF_A5_01_00_CD_AB_CD_AB, 1, 16'hABCD, 16'h0000, 1, 0, 0);
        vecs[2] = mkv(5, 80'hA5_00_00_00_00,             0, 16'h0000, 16'h0000, 1, 0, 0);
        vecs[3] = mkv(3, 80'hA5_01_20,                   0, 16'h0000, 16'h0000, 0, 1, 1);
        vecs[4] = mkv(7, 80'hA5_01_00_A5_A5_A5_A5,       1, 16'hA5A5, 16'h0000, 1, 0, 0);
        vecs[5] = mkv(7, 80'hA5_01_00_34_12_34_12,       1, 16'h1234, 16'h0000, 1, 0, 0);
        vecs[6] = mkv(7, 80'hA5_01_00_34_12_35_12,       1, 16'h1234, 16'h0000, 0, 1, 1);
`else
        vecs[0] = mkv(7, 80'hA5_02_00_34_12_78_56,       2, 16'h1234, 16'h5678, 1, 0, 0);
        vecs[1] = mkv(7, 80'h00_FF_A5_01_00_CD_AB,       1, 16'hABCD, 16'h0000, 1, 0, 0);
        vecs[2] = mkv(3, 80'hA5_00_00,                   0, 16'h0000, 16'h0000, 1, 0, 0);
        vecs[3] = mkv(3, 80'hA5_01_20,                   0, 16'h0000, 16'h0000, 0, 1, 1);
        vecs[4] = mkv(5, 80'hA5_01_00_A5_A5,             1, 16'hA5A5, 16'h0000, 1, 0, 0);
`endif
        repeat (2) @(negedge clk);
        check("rst mem_we",    32'(bus.mem_we),    32'd0);
        check("rst mem_addr",  32'(bus.mem_addr),  32'd0);
        check("rst mem_din",   32'(bus.mem_din),   32'd0);
        check("rst cpu_reset", 32'(bus.cpu_reset), 32'd1);
        check("rst busy",      32'(bus.busy),      32'd0);
        check("rst done",      32'(bus.done),      32'd0);
        check("rst error",     32'(bus.error),     32'd0);
        reset = 1'b0;

        for (int k = 0; k < NV; k++) apply(k);

        // n == 8192 is the largest legal count: the frame must be accepted, then abandoned
        send(8'hA5); send(8'h00); send(8'h20);
        check("n8192 busy",  32'(bus.busy),  32'd1);
        check("n8192 error", 32'(bus.error), 32'd0);
        repeat (110) @(negedge clk);
        check("n8192 timeout error", 32'(bus.error), 32'd1);

        // Silence mid-frame: abort exactly 100 cycles after the last byte
        base = wr_total;
        send(8'hA5); send(8'h02); send(8'h00); send(8'h34);
        repeat (95) @(negedge clk);
        check("to early error", 32'(bus.error), 32'd0);
        check("to early busy",  32'(bus.busy),  32'd1);
        repeat (10) @(negedge clk);
        check("to error",     32'(bus.error),     32'd1);
        check("to busy",      32'(bus.busy),      32'd0);
        check("to cpu_reset", 32'(bus.cpu_reset), 32'd1);
        check("to done",      32'(bus.done),      32'd0);
        check("to writes",    32'(wr_total - base), 32'd0);
        apply(0);

        // Async reset while waiting for a high data byte
        send(8'hA5); send(8'h01); send(8'h00); send(8'h34);
        check("ar pre busy", 32'(bus.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("ar mem_we",    32'(bus.mem_we),    32'd0);
        check("ar mem_addr",  32'(bus.mem_addr),  32'd0);
        check("ar mem_din",   32'(bus.mem_din),   32'd0);
        check("ar cpu_reset", 32'(bus.cpu_reset), 32'd1);
        check("ar busy",      32'(bus.busy),      32'd0);
        check("ar done",      32'(bus.done),      32'd0);
        check("ar error",     32'(bus.error),     32'd0);
        @(negedge clk);
        reset = 1'b0;
        apply(1);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
